// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle shared by a master and the CSR slave.
// The master modport drives requests and write data; the slave modport drives
// ready signals and responses.
interface axi4_lite_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_csr.sv
// AXI4-Lite slave exposing REG_AMOUNT read/write registers.
// AW and W are accepted independently and committed together; one write and
// one read may be in flight at once. Out-of-range indices answer SLVERR.
// Optional macro AXI4_LITE_CSR_WSTRB_EN enables byte-strobe merging; without
// it every in-range write replaces the full word.
module axi4_lite_csr #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_AMOUNT = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    axi4_lite_if.slave                            axi4_lite_i,
    output logic [REG_AMOUNT-1:0][DATA_WIDTH-1:0] regs_o,
    output logic [REG_AMOUNT-1:0]                 wr_stb_o
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW_HELD,
        S_W_HELD,
        S_RESP
    } wstate_t;

    wstate_t                              r_wstate;
    wstate_t                              w_wstate_next;
    logic                                 w_commit;
    logic                                 w_awready;
    logic                                 w_wready;
    logic                                 w_bvalid;
    logic                                 w_aw_hs;
    logic                                 w_w_hs;
    logic                                 w_ar_hs;

    logic [IDX_W-1:0]                     r_awidx;
    logic [DATA_WIDTH-1:0]                r_wdata;
    logic [IDX_W-1:0]                     w_widx;
    logic [DATA_WIDTH-1:0]                w_wdata;
    logic                                 w_win_range;
    logic [1:0]                           r_bresp;

    logic [IDX_W-1:0]                     w_aridx;
    logic                                 w_rin_range;
    logic [DATA_WIDTH-1:0]                w_rd_word;
    logic                                 r_rvalid;
    logic [DATA_WIDTH-1:0]                r_rdata;
    logic [1:0]                           r_rresp;

    logic [REG_AMOUNT-1:0][DATA_WIDTH-1:0] r_regs;
    logic [REG_AMOUNT-1:0]                 r_wr_stb;

    logic                                 w_unused;

`ifdef AXI4_LITE_CSR_WSTRB_EN
    logic [STRB_W-1:0]                    r_wstrb;
    logic [STRB_W-1:0]                    w_wstrb;

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign w_wstrb  = w_w_hs ? axi4_lite_i.wstrb : r_wstrb;
    assign w_unused = ^{axi4_lite_i.awprot, axi4_lite_i.arprot};
`else
    assign w_unused = ^{axi4_lite_i.awprot, axi4_lite_i.arprot, axi4_lite_i.wstrb};
`endif

    assign w_aw_hs = axi4_lite_i.awvalid && w_awready;
    assign w_w_hs  = axi4_lite_i.wvalid  && w_wready;
    assign w_ar_hs = axi4_lite_i.arvalid && !r_rvalid;

    // A channel handshaking this cycle supplies its value directly; otherwise
    // the previously held value is used.
    assign w_widx      = w_aw_hs ? axi4_lite_i.awaddr[ADDR_WIDTH-1:ADDR_LSB] : r_awidx;
    assign w_wdata     = w_w_hs  ? axi4_lite_i.wdata : r_wdata;
    assign w_win_range = (w_widx < IDX_W'(REG_AMOUNT));

    assign w_aridx     = axi4_lite_i.araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign w_rin_range = (w_aridx < IDX_W'(REG_AMOUNT));

    // Write-channel state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wstate <= S_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
        end
    end

    // Write-channel next state; commit fires when the second of AW/W lands.
    always_comb begin
        w_wstate_next = r_wstate;
        w_commit      = 1'b0;
        case (r_wstate)
            S_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_next = S_RESP;
                    w_commit      = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_next = S_AW_HELD;
                end else if (w_w_hs) begin
                    w_wstate_next = S_W_HELD;
                end
            end
            S_AW_HELD: begin
                if (w_w_hs) begin
                    w_wstate_next = S_RESP;
                    w_commit      = 1'b1;
                end
            end
            S_W_HELD: begin
                if (w_aw_hs) begin
                    w_wstate_next = S_RESP;
                    w_commit      = 1'b1;
                end
            end
            S_RESP: begin
                if (axi4_lite_i.bready) begin
                    w_wstate_next = S_IDLE;
                end
            end
            default: w_wstate_next = S_IDLE;
        endcase
    end

    // Write-channel outputs decoded from state.
    always_comb begin
        w_awready = (r_wstate == S_IDLE) || (r_wstate == S_W_HELD);
        w_wready  = (r_wstate == S_IDLE) || (r_wstate == S_AW_HELD);
        w_bvalid  = (r_wstate == S_RESP);
    end

    // Capture the early channel's payload until its partner arrives.
    always_ff @(posedge clk_i) begin
        if (w_aw_hs) begin
            r_awidx <= axi4_lite_i.awaddr[ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_w_hs) begin
            r_wdata <= axi4_lite_i.wdata;
`ifdef AXI4_LITE_CSR_WSTRB_EN
            r_wstrb <= axi4_lite_i.wstrb;
`endif
        end
    end

    // Register file update and per-register write strobe pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_regs   <= '0;
            r_wr_stb <= '0;
        end else begin
            r_wr_stb <= '0;
            if (w_commit && w_win_range) begin
                for (int i = 0; i < REG_AMOUNT; i++) begin
                    if (w_widx == IDX_W'(i)) begin
`ifdef AXI4_LITE_CSR_WSTRB_EN
                        r_regs[i] <= merge_bytes(r_regs[i], w_wdata, w_wstrb);
`else
                        r_regs[i] <= w_wdata;
`endif
                        r_wr_stb[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Write response code, latched at commit and held through the B phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bresp <= RESP_OKAY;
        end else if (w_commit) begin
            r_bresp <= w_win_range ? RESP_OKAY : RESP_SLVERR;
        end else if (w_bvalid && axi4_lite_i.bready) begin
            r_bresp <= RESP_OKAY;
        end
    end

    // Read mux over the register file (pre-write contents on a same-edge write).
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < REG_AMOUNT; i++) begin
            if (w_aridx == IDX_W'(i)) begin
                w_rd_word = r_regs[i];
            end
        end
    end

    // Read channel: register the response on AR, clear it on R handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rin_range ? w_rd_word : '0;
            r_rresp  <= w_rin_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && axi4_lite_i.rready) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end
    end

    assign axi4_lite_i.awready = w_awready;
    assign axi4_lite_i.wready  = w_wready;
    assign axi4_lite_i.bvalid  = w_bvalid;
    assign axi4_lite_i.bresp   = r_bresp;
    assign axi4_lite_i.arready = !r_rvalid;
    assign axi4_lite_i.rvalid  = r_rvalid;
    assign axi4_lite_i.rdata   = r_rdata;
    assign axi4_lite_i.rresp   = r_rresp;

    assign regs_o   = r_regs;
    assign wr_stb_o = r_wr_stb;
endmodule
